fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains bytes from an upstream FIFO and sends them as 8N1 UART frames, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      START,
      DATA,
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   state_t           state_q;
   logic [15:0]      baud_q;
   logic [2:0]       bitIdx_q;
   logic [WIDTH-1:0] shift_q;
   logic             tx_q;
   logic             busy_q;
   logic             rdEn_q;
   logic             armed_q;
`ifdef FIFO_UART_TX_PARITY_EN
   logic             parity_q;
`endif

   logic baudDone;

   assign baudDone   = (baud_q == BAUD_LAST);
   assign fifo_rd_en = rdEn_q;
   assign tx         = tx_q;
   assign busy       = busy_q;

   // armed_q holds off the first FIFO read until the second edge after reset is released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         rdEn_q   <= 1'b0;
         armed_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         armed_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (armed_q && !fifo_empty) begin
                  state_q <= REQ;
                  rdEn_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end

            REQ: begin
               state_q <= WAIT;
               rdEn_q  <= 1'b0;
            end

            WAIT: begin
               shift_q <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
               parity_q <= ^fifo_data;
`endif
               state_q <= START;
               tx_q    <= 1'b0;
               baud_q  <= '0;
            end

            START: begin
               if (baudDone) begin
                  state_q  <= DATA;
                  baud_q   <= '0;
                  bitIdx_q <= '0;
                  tx_q     <= shift_q[0];
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end

            DATA: begin
               if (baudDone) begin
                  baud_q <= '0;
                  if (bitIdx_q == 3'd7) begin
                     bitIdx_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                     state_q <= PARITY;
                     tx_q    <= parity_q;
`else
                     state_q <= STOP;
                     tx_q    <= 1'b1;
`endif
                  end else begin
                     bitIdx_q <= bitIdx_q + 3'd1;
                     tx_q     <= shift_q[bitIdx_q + 3'd1];
                  end
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
               if (baudDone) begin
                  state_q <= STOP;
                  baud_q  <= '0;
                  tx_q    <= 1'b1;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
`endif

            // A waiting byte is fetched straight out of the stop bit, with no idle bit time.
            STOP: begin
               if (baudDone) begin
                  baud_q <= '0;
                  if (!fifo_empty) begin
                     state_q <= REQ;
                     rdEn_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end

            default: begin
               state_q <= IDLE;
               baud_q  <= '0;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               rdEn_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a model FIFO feeds the DUT and a monitor decodes tx frames.
// Expected frames are queued when bytes are written; the monitor pops one per decoded frame.
module tb_fifo_uart_tx;

   localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   typedef struct {
      logic [7:0] data;
      int         gap;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [7:0] fifo_data;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic       tx;
   logic       busy;

   int testsRun = 0;
   int testsFailed = 0;
   int rdCount = 0;

   logic [7:0] fifoQ[$];
   logic [7:0] writeQ[$];
   exp_t       expQ[$];

   fifo_uart_tx #(
      .WIDTH(8),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fifo_data(fifo_data),
      .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en),
      .tx(tx),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] data, input int gap);
      exp_t e;
      e.data = data;
      e.gap  = gap;
      writeQ.push_back(data);
      expQ.push_back(e);
   endtask

   task automatic waitTxLow(input int limit, output int n);
      n = 0;
      while (tx !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic waitBusyLow(input int limit, output int n);
      n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Upstream FIFO model: registered read data and empty flag, not cleared by the DUT reset.
   initial begin
      fifo_data  = 8'h00;
      fifo_empty = 1'b1;
   end

   always @(posedge clk) begin
      if (fifo_rd_en === 1'b1) begin
         rdCount++;
         checkOutput("rd_en_while_empty", 32'(fifoQ.size() != 0), 32'd1);
         if (fifoQ.size() != 0) fifo_data <= fifoQ.pop_front();
      end
      while (writeQ.size() != 0) fifoQ.push_back(writeQ.pop_front());
      fifo_empty <= (fifoQ.size() == 0);
   end

   // Monitor: decodes each frame from its first low sample and compares against the scoreboard.
   initial begin : monitor
      int         negCyc;
      int         lastStopNeg;
      int         startNeg;
      logic [NB-1:0] bits;
      logic [NB-1:0] expBits;
      bit         abort;
      bit         glitch;
      exp_t       e;
      negCyc      = 0;
      lastStopNeg = -1000;
      forever begin
         @(negedge clk);
         negCyc++;
         if (rst === 1'b0 && tx === 1'b0) begin
            startNeg = negCyc;
            abort    = 1'b0;
            glitch   = 1'b0;
            bits     = '0;
            for (int b = 0; b < NB && !abort; b++) begin
               for (int s = 0; s < CPB && !abort; s++) begin
                  if (!(b == 0 && s == 0)) begin
                     @(negedge clk);
                     negCyc++;
                  end
                  if (rst === 1'b1) abort = 1'b1;
                  else if (s == 0) bits[b] = tx;
                  else if (tx !== bits[b]) glitch = 1'b1;
               end
            end
            if (abort) begin
               if (expQ.size() != 0) void'(expQ.pop_front());
            end else begin
               checkOutput("frame_expected", 32'(expQ.size() != 0), 32'd1);
               if (expQ.size() != 0) begin
                  e = expQ.pop_front();
`ifdef FIFO_UART_TX_PARITY_EN
                  expBits = {1'b1, ^e.data, e.data, 1'b0};
`else
                  expBits = {1'b1, e.data, 1'b0};
`endif
                  checkOutput("frame_bits", 32'(bits), 32'(expBits));
                  checkOutput("frame_stable", 32'(glitch), 32'd0);
                  if (e.gap >= 0)
                     checkOutput("frame_gap", 32'(startNeg - lastStopNeg), 32'(e.gap));
               end
               lastStopNeg = negCyc;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      int n;
      int rd0;
      int bad;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_tx", 32'(tx), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'd0);
      rst = 1'b0;

      // Empty FIFO: line stays idle.
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
      end
      checkOutput("idle_200", 32'(bad), 32'd0);

      // Single byte A1: one read, frame length, line back to idle.
      rd0 = rdCount;
      applyStimulus(8'hA1, -1);
      waitTxLow(20, n);
      checkOutput("a1_start_seen", 32'(n < 20), 32'd1);
      waitBusyLow(200, n);
      checkOutput("a1_frame_len", 32'(n), 32'(FRAME));
      repeat (5) @(negedge clk);
      checkOutput("a1_rd_pulses", 32'(rdCount - rd0), 32'd1);
      checkOutput("a1_tx_idle", 32'(tx), 32'd1);
      checkOutput("a1_busy_idle", 32'(busy), 32'd0);

      // A1 then B2 queued mid-frame: back-to-back frames, two idle cycles between them.
      rd0 = rdCount;
      applyStimulus(8'hA1, -1);
      repeat (10) @(negedge clk);
      applyStimulus(8'hB2, 3);
      waitBusyLow(300, n);
      checkOutput("ab_done", 32'(n < 300), 32'd1);
      repeat (5) @(negedge clk);
      checkOutput("ab_rd_pulses", 32'(rdCount - rd0), 32'd2);

      // C3 aborted by reset in data bit 3.
      rd0 = rdCount;
      applyStimulus(8'hC3, -1);
      waitTxLow(20, n);
      checkOutput("c3_start_seen", 32'(n < 20), 32'd1);
      repeat (17) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_tx", 32'(tx), 32'd1);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_rd_en", 32'(fifo_rd_en), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      checkOutput("post_abort_idle", 32'(bad), 32'd0);
      checkOutput("abort_rd_pulses", 32'(rdCount - rd0), 32'd1);
      checkOutput("abort_fifo_level", 32'(fifoQ.size() + writeQ.size()), 32'd0);

      // Byte waiting across reset release: no read on the first edge.
      rst = 1'b1;
      rd0 = rdCount;
      applyStimulus(8'h5A, -1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("first_edge_rd_en", 32'(fifo_rd_en), 32'd0);
      waitTxLow(20, n);
      checkOutput("5a_start_seen", 32'(n < 20), 32'd1);
      waitBusyLow(200, n);
      checkOutput("5a_frame_len", 32'(n), 32'(FRAME));
      repeat (10) @(negedge clk);
      checkOutput("5a_rd_pulses", 32'(rdCount - rd0), 32'd1);
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
